// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix multiplier C = A x B (optional C += A x B), M x N PEs, run-time K <= KMAX.
// Optional SYSTOLIC_SAT_EN: saturate output elements after the FRAC shift instead of wrapping.
module systolic_mm_engine #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 0,
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int KMAX   = 16,
  parameter int AWIDTH = 2*DWIDTH+$clog2(KMAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(KMAX+1)-1:0]  k_len,
  input  logic                       acc_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [M*DWIDTH-1:0]        a_col,
  input  logic [N*DWIDTH-1:0]        b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*DWIDTH-1:0]        out_row,
  output logic [$clog2(M)-1:0]       out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int KW  = $clog2(KMAX+1);
  localparam int RW  = $clog2(M);
  localparam int DRW = $clog2(M+N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k_eff, k_clamp, beat_cnt;
  logic [DRW-1:0]  drain_cnt;
  logic [RW-1:0]   r;
  logic            accept, last_beat, clr;

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [AWIDTH-1:0] SAT_MAX = AWIDTH'((64'sd1 <<< (DWIDTH-1)) - 64'sd1);
  localparam logic signed [AWIDTH-1:0] SAT_MIN = -SAT_MAX - AWIDTH'(1);

  function automatic logic [DWIDTH-1:0] fmt(input logic signed [AWIDTH-1:0] v);
    logic signed [AWIDTH-1:0] sh;
    sh = v >>> FRAC;
    if (sh > SAT_MAX) return SAT_MAX[DWIDTH-1:0];
    if (sh < SAT_MIN) return SAT_MIN[DWIDTH-1:0];
    return sh[DWIDTH-1:0];
  endfunction
`else
  function automatic logic [DWIDTH-1:0] fmt(input logic signed [AWIDTH-1:0] v);
    return DWIDTH'(v >>> FRAC);
  endfunction
`endif

  assign k_clamp   = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign accept    = in_valid && (state == LOAD);
  assign last_beat = ((beat_cnt + KW'(1)) == k_eff);
  assign clr       = (state == IDLE) && start && !acc_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (k_len == '0) ? OUTPUT : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRW'(M+N-2)) state_nx = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && (r == RW'(M-1))) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_eff     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      r         <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          beat_cnt  <= '0;
          drain_cnt <= '0;
          r         <= '0;
          if (start) k_eff <= k_clamp;
        end
        LOAD:  if (accept) beat_cnt <= beat_cnt + KW'(1);
        DRAIN: drain_cnt <= drain_cnt + DRW'(1);
        OUTPUT: begin
          if (out_ready) begin
            if (r == RW'(M-1)) begin
              r    <= '0;
              done <= 1'b1;
            end else begin
              r <= r + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // p0: operand capture; bubbles carry vld_p0 = 0
  logic signed [DWIDTH-1:0] a_p0 [M];
  logic signed [DWIDTH-1:0] b_p0 [N];
  logic                     vld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      for (int i = 0; i < M; i++) a_p0[i] <= '0;
      for (int j = 0; j < N; j++) b_p0[j] <= '0;
    end else begin
      vld_p0 <= accept;
      for (int i = 0; i < M; i++) a_p0[i] <= a_col[i*DWIDTH +: DWIDTH];
      for (int j = 0; j < N; j++) b_p0[j] <= b_row[j*DWIDTH +: DWIDTH];
    end
  end

  // skew: row i of A delayed i cycles, column j of B delayed j cycles
  logic signed [DWIDTH-1:0] a_edge [M];
  logic                     va_edge [M];
  logic signed [DWIDTH-1:0] b_edge [N];
  logic                     vb_edge [N];

  for (genvar i = 0; i < M; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_edge[i]  = a_p0[i];
      assign va_edge[i] = vld_p0;
    end else begin : g_chain
      logic signed [DWIDTH-1:0] sr [i];
      logic                     sv [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            sr[s] <= '0;
            sv[s] <= 1'b0;
          end
        end else begin
          sr[0] <= a_p0[i];
          sv[0] <= vld_p0;
          for (int s = 1; s < i; s++) begin
            sr[s] <= sr[s-1];
            sv[s] <= sv[s-1];
          end
        end
      end
      assign a_edge[i]  = sr[i-1];
      assign va_edge[i] = sv[i-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_edge[j]  = b_p0[j];
      assign vb_edge[j] = vld_p0;
    end else begin : g_chain
      logic signed [DWIDTH-1:0] sr [j];
      logic                     sv [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < j; s++) begin
            sr[s] <= '0;
            sv[s] <= 1'b0;
          end
        end else begin
          sr[0] <= b_p0[j];
          sv[0] <= vld_p0;
          for (int s = 1; s < j; s++) begin
            sr[s] <= sr[s-1];
            sv[s] <= sv[s-1];
          end
        end
      end
      assign b_edge[j]  = sr[j-1];
      assign vb_edge[j] = sv[j-1];
    end
  end

  // PE array: a moves right, b moves down, accumulators stay in place
  logic signed [DWIDTH-1:0] a_pe  [M][N];
  logic                     va_pe [M][N];
  logic signed [DWIDTH-1:0] b_pe  [M][N];
  logic                     vb_pe [M][N];
  logic signed [AWIDTH-1:0] acc   [M][N];

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DWIDTH-1:0]   ai, bi;
      logic                       vai, vbi;
      logic signed [2*DWIDTH-1:0] prod;

      if (j == 0) begin : g_ain_edge
        assign ai  = a_edge[i];
        assign vai = va_edge[i];
      end else begin : g_ain_pe
        assign ai  = a_pe[i][j-1];
        assign vai = va_pe[i][j-1];
      end

      if (i == 0) begin : g_bin_edge
        assign bi  = b_edge[j];
        assign vbi = vb_edge[j];
      end else begin : g_bin_pe
        assign bi  = b_pe[i-1][j];
        assign vbi = vb_pe[i-1][j];
      end

      assign prod = ai * bi;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_pe[i][j]  <= '0;
          va_pe[i][j] <= 1'b0;
          b_pe[i][j]  <= '0;
          vb_pe[i][j] <= 1'b0;
          acc[i][j]   <= '0;
        end else begin
          a_pe[i][j]  <= ai;
          va_pe[i][j] <= vai;
          b_pe[i][j]  <= bi;
          vb_pe[i][j] <= vbi;
          if (clr)             acc[i][j] <= '0;
          else if (vai && vbi) acc[i][j] <= acc[i][j] + AWIDTH'(prod);
        end
      end
    end
  end

  // output: row r read straight from the accumulators, which are static in OUTPUT
  always_comb begin
    out_row  = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (state == OUTPUT) begin
      for (int j = 0; j < N; j++) out_row[j*DWIDTH +: DWIDTH] = fmt(acc[r][j]);
      out_idx  = r;
      out_last = (r == RW'(M-1));
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomised and directed bench for systolic_mm_engine against a plain matrix-product reference model.
module tb_systolic_mm_engine;

  localparam int DW   = 16;
  localparam int FRAC = 0;
  localparam int M    = 4;
  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int AW   = 2*DW+$clog2(KMAX);
  localparam int KW   = $clog2(KMAX+1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [KW-1:0]      k_len;
  logic               acc_mode;
  logic               in_valid;
  logic               in_ready;
  logic [M*DW-1:0]    a_col;
  logic [N*DW-1:0]    b_row;
  logic               out_valid;
  logic               out_ready;
  logic [N*DW-1:0]    out_row;
  logic [$clog2(M)-1:0] out_idx;
  logic               out_last;
  logic               busy;
  logic               done;

  systolic_mm_engine #(.DWIDTH(DW), .FRAC(FRAC), .M(M), .N(N), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     errors = 0;
  int     checks = 0;
  int     A [M][KMAX];
  int     B [KMAX][N];
  longint macc [M][N];
  int     s_cyc;
  logic [DW-1:0] first_elem;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrapa(input longint v);
    longint m;
    m = v & ((64'sd1 <<< AW) - 1);
    if (m[AW-1]) m = m - (64'sd1 <<< AW);
    return m;
  endfunction

  function automatic logic [DW-1:0] model_fmt(input longint v);
    longint s;
    s = v >>> FRAC;
`ifdef SYSTOLIC_SAT_EN
    if (s > ((64'sd1 <<< (DW-1)) - 1)) s = (64'sd1 <<< (DW-1)) - 1;
    if (s < -(64'sd1 <<< (DW-1)))      s = -(64'sd1 <<< (DW-1));
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = model_fmt(macc[r][j]);
    return v;
  endfunction

  function automatic int rnd16();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return int'(v);
  endfunction

  task automatic fill_const(input int va, input int vb);
    for (int i = 0; i < M; i++) for (int k = 0; k < KMAX; k++) A[i][k] = va;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) B[k][j] = vb;
  endtask

  task automatic fill_identity();
    for (int i = 0; i < M; i++) for (int k = 0; k < KMAX; k++) A[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) B[k][j] = k*4 + j;
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++) for (int k = 0; k < KMAX; k++) A[i][k] = rnd16();
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < N; j++) B[k][j] = rnd16();
  endtask

  task automatic start_job(input int k, input bit mode, output int keff);
    keff = (k > KMAX) ? KMAX : k;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        if (!mode) macc[i][j] = 0;
        for (int kk = 0; kk < keff; kk++)
          macc[i][j] = wrapa(macc[i][j] + longint'(A[i][kk]) * longint'(B[kk][j]));
      end
    s_cyc    = cyc;
    start    = 1'b1;
    k_len    = KW'(k);
    acc_mode = mode;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(input int gap, input int keff);
    int idx;
    int t;
    logic [DW-1:0] e;
    idx = 0;
    t   = 0;
    while (in_ready === 1'b1 && t < 400) begin
      in_valid = (gap == 0) || (t % 2 == 0);
      for (int i = 0; i < M; i++) begin
        e = '0;
        if (idx < KMAX) e = DW'(A[i][idx]);
        a_col[i*DW +: DW] = e;
      end
      for (int j = 0; j < N; j++) begin
        e = '0;
        if (idx < KMAX) e = DW'(B[idx][j]);
        b_row[j*DW +: DW] = e;
      end
      if (in_valid) idx++;
      tick();
      t++;
    end
    in_valid = 1'b0;
    check("beats", idx, keff);
  endtask

  task automatic drain_rows(input int stall_row, input int exp_lat);
    int n;
    logic [63:0] er;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("out_valid_wait", out_valid, 1);
    if (exp_lat >= 0) check("latency", cyc - s_cyc, exp_lat);
    for (int r = 0; r < M; r++) begin
      er = exp_row(r);
      out_ready = 1'b0;
      if (r == stall_row) begin
        for (int s = 0; s < 3; s++) begin
          check($sformatf("stall_row%0d", r), out_row, er);
          check($sformatf("stall_idx%0d", r), out_idx, r);
          check($sformatf("stall_valid%0d", r), out_valid, 1);
          tick();
        end
      end
      out_ready = 1'b1;
      check($sformatf("valid%0d", r), out_valid, 1);
      check($sformatf("row%0d", r), out_row, er);
      check($sformatf("idx%0d", r), out_idx, r);
      check($sformatf("last%0d", r), out_last, (r == M-1));
      if (r == 0) first_elem = out_row[DW-1:0];
      tick();
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("valid_after", out_valid, 0);
    check("busy_after", busy, 0);
    tick();
    check("done_cleared", done, 0);
  endtask

  task automatic run_job(input int k, input bit mode, input int gap, input int stall_row, input int exp_lat);
    int keff;
    start_job(k, mode, keff);
    feed(gap, keff);
    drain_rows(stall_row, exp_lat);
  endtask

  initial begin
    int keff;
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    acc_mode  = 1'b0;
    in_valid  = 1'b0;
    a_col     = '0;
    b_row     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) macc[i][j] = 0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // identity, then bubbles with backpressure on row 1
    fill_identity();
    run_job(4, 1'b0, 0, -1, 12);
    check("ident_elem00", first_elem, 16'd0);
    run_job(4, 1'b0, 1, 1, -1);

    // accumulate chain: 2, 4, 2
    fill_const(1, 1);
    run_job(2, 1'b0, 0, -1, 2 + M + N);
    check("acc_job1", first_elem, 16'd2);
    run_job(2, 1'b1, 0, -1, -1);
    check("acc_job2", first_elem, 16'd4);
    run_job(2, 1'b0, 0, 2, -1);
    check("acc_job3", first_elem, 16'd2);

    // K=0 goes straight to OUTPUT; oversize K clamps to KMAX
    run_job(0, 1'b0, 0, -1, 1);
    check("k0_elem", first_elem, 16'd0);
    fill_random();
    run_job(KMAX + 3, 1'b0, 0, -1, KMAX + M + N);

    // large positive sums: wrap or saturate
    fill_const(16'sh7FFF, 16'sh7FFF);
    run_job(4, 1'b0, 0, -1, -1);
`ifdef SYSTOLIC_SAT_EN
    check("sat_elem", first_elem, 16'h7FFF);
`else
    check("wrap_elem", first_elem, 16'h0004);
`endif

    // random jobs, mixed accumulate mode
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_job(1 + int'($urandom_range(KMAX - 1)), 1'(n > 0 && $urandom_range(1) == 1),
              int'($urandom_range(1)), int'($urandom_range(M - 1)), -1);
    end

    // reset during DRAIN aborts the job and clears the accumulators
    fill_const(1, 1);
    start_job(4, 1'b0, keff);
    feed(0, keff);
    tick();
    check("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_row", out_row, 0);
    check("mid_rst_done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) macc[i][j] = 0;
    tick();
    check("post_rst_done", done, 0);
    run_job(1, 1'b1, 0, -1, 1 + M + N);
    check("post_rst_acc", first_elem, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
